// File: rtl/adder_pkg.sv
// Shared types and constants for the bit-serial adder.
// Imported by the controller and its bench.
package adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int SERIAL_ADDER_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/g_fulladder.sv
// Gate-level one-bit full adder.
// Generate/propagate form built from primitives.
module g_fulladder (
  input  wire a,
  input  wire b,
  input  wire cin,
  output wire sum,
  output wire cout
);

  wire p;
  wire g;
  wire t;

  xor x_p (p, a, b);
  xor x_s (sum, p, cin);
  and a_g (g, a, b);
  and a_t (t, p, cin);
  or  o_c (cout, g, t);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full adder stepped over WIDTH bits,
// LSB first, with latched operands and a done pulse.
module serial_adder_ctrl
  import adder_pkg::*;
#(
  parameter int WIDTH = SERIAL_ADDER_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_MSB  = CW'(WIDTH - 2);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t state;
  state_t state_nx;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  // Holds the low WIDTH-1 result bits; bit 1 ends up as sum[0].
  logic [WIDTH-1:1] s_sh;
  logic [WIDTH-1:0] s_nx;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             cmsb;
  logic             fa_sum;
  logic             fa_cout;
  logic             load;
  logic             last;

  g_fulladder u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  assign s_nx = {fa_sum, s_sh};
  assign load = start && (state != ST_ADD);
  assign last = (state == ST_ADD) && (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) state_nx = ST_ADD;
      end
      ST_ADD: begin
        busy = 1'b1;
        if (cnt == CNT_LAST) state_nx = ST_DONE;
      end
      ST_DONE: begin
        done     = 1'b1;
        state_nx = start ? ST_ADD : ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh  <= '0;
      b_sh  <= '0;
      s_sh  <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      cmsb  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (load) begin
      a_sh  <= a;
      b_sh  <= b;
      s_sh  <= '0;
      cnt   <= '0;
      carry <= cin;
      cmsb  <= 1'b0;
    end else if (state == ST_ADD) begin
      a_sh  <= a_sh >> 1;
      b_sh  <= b_sh >> 1;
      s_sh  <= s_nx[WIDTH-1:1];
      carry <= fa_cout;
      cnt   <= last ? '0 : cnt + CW'(1);
      if (cnt == CNT_MSB) cmsb <= fa_cout;
      if (last) begin
        sum  <= s_nx;
        cout <= fa_cout;
        ovf  <= cmsb ^ fa_cout;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed and random checks of serial_adder_ctrl
// at WIDTH=8 and WIDTH=2.
module tb_serial_adder_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start8, cin8, busy8, done8, cout8, ovf8;
  logic [7:0] a8, b8, sum8;
  logic       start2, cin2, busy2, done2, cout2, ovf2;
  logic [1:0] a2, b2, sum2;
  int         tests = 0;
  int         fails = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8),
    .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8),
    .cout(cout8), .ovf(ovf8)
  );

  serial_adder_ctrl #(.WIDTH(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2),
    .a(a2), .b(b2), .cin(cin2),
    .busy(busy2), .done(done2), .sum(sum2),
    .cout(cout2), .ovf(ovf2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts one WIDTH=8 op; returns at the done cycle (or timeout).
  task automatic op8(input logic [7:0] ai, input logic [7:0] bi,
                     input logic ci, output int lat,
                     output int bn);
    a8 = ai; b8 = bi; cin8 = ci; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    lat = 1;
    bn = 0;
    while (!done8 && lat < 40) begin
      if (busy8) bn++;
      tick();
      lat++;
    end
  endtask

  task automatic op2(input logic [1:0] ai, input logic [1:0] bi,
                     input logic ci, output int lat);
    a2 = ai; b2 = bi; cin2 = ci; start2 = 1'b1;
    tick();
    start2 = 1'b0;
    lat = 1;
    while (!done2 && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;
    repeat (2) tick();
    tests++;
    if ({busy8, done8, cout8, ovf8, sum8} !== 12'h000) begin
      fails++;
      $display("FAIL reset8: got b%b d%b c%b o%b s%h want all 0",
               busy8, done8, cout8, ovf8, sum8);
    end
    tests++;
    if ({busy2, done2, cout2, ovf2, sum2} !== 6'h00) begin
      fails++;
      $display("FAIL reset2: got b%b d%b c%b o%b s%h want all 0",
               busy2, done2, cout2, ovf2, sum2);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int lat, bn;
    op8(8'h5A, 8'h3C, 1'b0, lat, bn);
    tests++;
    if (lat !== 9 || bn !== 8) begin
      fails++;
      $display("FAIL basic_timing: got lat=%0d busy=%0d want 9/8",
               lat, bn);
    end
    tests++;
    if ({busy8, cout8, ovf8, sum8} !== {3'b001, 8'h96}) begin
      fails++;
      $display("FAIL basic_result: got b%b c%b o%b s%h want 0/0/1/96",
               busy8, cout8, ovf8, sum8);
    end
  endtask

  task automatic test_carry();
    int lat, bn;
    op8(8'hFF, 8'h01, 1'b0, lat, bn);
    tests++;
    if ({cout8, ovf8, sum8} !== {2'b10, 8'h00} || lat !== 9) begin
      fails++;
      $display("FAIL carry_ff01: got c%b o%b s%h lat%0d want 1/0/00/9",
               cout8, ovf8, sum8, lat);
    end
    op8(8'hFF, 8'h00, 1'b1, lat, bn);
    tests++;
    if ({cout8, ovf8, sum8} !== {2'b10, 8'h00} || lat !== 9) begin
      fails++;
      $display("FAIL carry_cin: got c%b o%b s%h lat%0d want 1/0/00/9",
               cout8, ovf8, sum8, lat);
    end
  endtask

  task automatic test_overflow();
    int lat, bn;
    op8(8'h7F, 8'h01, 1'b0, lat, bn);
    tests++;
    if ({cout8, ovf8, sum8} !== {2'b01, 8'h80}) begin
      fails++;
      $display("FAIL ovf_pos: got c%b o%b s%h want 0/1/80",
               cout8, ovf8, sum8);
    end
    op8(8'h80, 8'h80, 1'b0, lat, bn);
    tests++;
    if ({cout8, ovf8, sum8} !== {2'b11, 8'h00}) begin
      fails++;
      $display("FAIL ovf_neg: got c%b o%b s%h want 1/1/00",
               cout8, ovf8, sum8);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    a8 = 8'h11; b8 = 8'h22; cin8 = 1'b0; start8 = 1'b1;
    tick();
    a8 = 8'hFF; b8 = 8'hFF;
    n = 0;
    while (!done8 && n < 40) begin
      tick();
      n++;
    end
    tests++;
    if ({cout8, sum8} !== 9'h033 || n !== 8) begin
      fails++;
      $display("FAIL busy_ignore: got c%b s%h n%0d want 0/33/8",
               cout8, sum8, n);
    end
    tick();
    start8 = 1'b0;
    tests++;
    if ({busy8, done8} !== 2'b10) begin
      fails++;
      $display("FAIL b2b_accept: got busy%b done%b want 1/0",
               busy8, done8);
    end
    n = 1;
    while (!done8 && n < 40) begin
      tick();
      n++;
    end
    tests++;
    if ({cout8, ovf8, sum8} !== {2'b10, 8'hFE} || n !== 9) begin
      fails++;
      $display("FAIL b2b_result: got c%b o%b s%h n%0d want 1/0/FE/9",
               cout8, ovf8, sum8, n);
    end
  endtask

  task automatic test_reset_abort();
    int nd, lat, bn;
    a8 = 8'h0F; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tests++;
    if ({busy8, done8, cout8, ovf8, sum8} !== 12'h000) begin
      fails++;
      $display("FAIL abort_clear: got b%b d%b c%b o%b s%h want all 0",
               busy8, done8, cout8, ovf8, sum8);
    end
    nd = 0;
    repeat (12) begin
      tick();
      if (done8 || busy8) nd++;
    end
    tests++;
    if (nd !== 0) begin
      fails++;
      $display("FAIL abort_quiet: got %0d active cycles want 0", nd);
    end
    op8(8'h0F, 8'h01, 1'b0, lat, bn);
    tests++;
    if ({cout8, ovf8, sum8} !== {2'b00, 8'h10} || lat !== 9) begin
      fails++;
      $display("FAIL abort_fresh: got c%b o%b s%h lat%0d want 0/0/10/9",
               cout8, ovf8, sum8, lat);
    end
  endtask

  task automatic test_random8();
    logic [7:0] ra, rb;
    logic       rc, eo;
    logic [8:0] ex;
    int         lat, bn;
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 5)) tick();
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      ex = {1'b0, ra} + {1'b0, rb} + {8'h00, rc};
      eo = (ra[7] == rb[7]) && (ex[7] != ra[7]);
      op8(ra, rb, rc, lat, bn);
      tests++;
      if ({cout8, sum8} !== ex || ovf8 !== eo
          || lat !== 9 || bn !== 8) begin
        fails++;
        $display("FAIL rand8 %h+%h+%b: got %h o%b lat%0d want %h o%b",
                 ra, rb, rc, {cout8, sum8}, ovf8, lat, ex, eo);
      end
    end
  endtask

  task automatic test_random2();
    logic [1:0] ra, rb;
    logic       rc, eo;
    logic [2:0] ex;
    int         lat;
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 5)) tick();
      ra = 2'($urandom);
      rb = 2'($urandom);
      rc = 1'($urandom);
      ex = {1'b0, ra} + {1'b0, rb} + {2'b00, rc};
      eo = (ra[1] == rb[1]) && (ex[1] != ra[1]);
      op2(ra, rb, rc, lat);
      tests++;
      if ({cout2, sum2} !== ex || ovf2 !== eo || lat !== 3) begin
        fails++;
        $display("FAIL rand2 %h+%h+%b: got %h o%b lat%0d want %h o%b",
                 ra, rb, rc, {cout2, sum2}, ovf2, lat, ex, eo);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_overflow();
    test_back_to_back();
    test_reset_abort();
    test_random8();
    test_random2();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
